// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants for the scan driver.
// Glyphs are active-low and packed as {g,f,e,d,c,b,a}, so bit 0 is segment a.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_ERR   = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-low 7-segment glyph; decimal-only mode shows "E" for 10..15.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output seg_t       o_glyph
);

    // Pure lookup; letters only when hex glyphs are enabled.
    always_comb begin
        o_glyph = SEG_ERR;
        case (i_nibble)
            4'h0:    o_glyph = SEG_0;
            4'h1:    o_glyph = SEG_1;
            4'h2:    o_glyph = SEG_2;
            4'h3:    o_glyph = SEG_3;
            4'h4:    o_glyph = SEG_4;
            4'h5:    o_glyph = SEG_5;
            4'h6:    o_glyph = SEG_6;
            4'h7:    o_glyph = SEG_7;
            4'h8:    o_glyph = SEG_8;
            4'h9:    o_glyph = SEG_9;
            4'hA:    o_glyph = i_hex_mode ? SEG_A : SEG_ERR;
            4'hB:    o_glyph = i_hex_mode ? SEG_B : SEG_ERR;
            4'hC:    o_glyph = i_hex_mode ? SEG_C : SEG_ERR;
            4'hD:    o_glyph = i_hex_mode ? SEG_D : SEG_ERR;
            4'hE:    o_glyph = i_hex_mode ? SEG_E : SEG_ERR;
            4'hF:    o_glyph = i_hex_mode ? SEG_F : SEG_ERR;
            default: o_glyph = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed N-digit 7-segment driver: shadow latch, prescaled digit scan,
// leading-zero blanking and one blank cycle between digits (break-before-make).
module seg_scan_drv
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int HEX_MODE = 0,
    parameter int LZ_BLANK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   din,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int                PW       = $clog2(SCAN_DIV);
    localparam int                IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_TC = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic              HEX_EN   = 1'(HEX_MODE != 0);
    localparam logic              LZ_EN    = 1'(LZ_BLANK != 0);
    // A single-digit display keeps its anode on permanently; only seg blanks.
    localparam logic [N_DIGITS-1:0] AN_GAP = {N_DIGITS{1'(N_DIGITS != 1)}};

    logic [4*N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]   r_dp;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic                  r_dp_n;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_frame;

    logic                  w_tick;
    logic [3:0]            w_nibble;
    logic                  w_dp_bit;
    logic                  w_zero_hi;
    logic                  w_hide;
    logic [N_DIGITS-1:0]   w_an_sel;
    logic [N_DIGITS-1:0]   w_zero_from;
    seg_t                  w_glyph;

    assign w_tick = (r_presc == PRESC_TC);

    // Per digit: is this nibble and every more significant nibble zero?
    always_comb begin
        w_zero_from = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_zero_from[i] = ((r_shadow >> (4 * i)) == '0);
        end
    end

    // Select the current digit's nibble, dp bit and zero flag; AND-OR mux form.
    always_comb begin
        w_nibble  = 4'h0;
        w_dp_bit  = 1'b0;
        w_zero_hi = 1'b0;
        w_an_sel  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_nibble    = w_nibble | ((r_idx == IW'(i)) ? r_shadow[4*i +: 4] : 4'h0);
            w_dp_bit    = w_dp_bit | ((r_idx == IW'(i)) & r_dp[i]);
            w_zero_hi   = w_zero_hi | ((r_idx == IW'(i)) & w_zero_from[i]);
            w_an_sel[i] = (r_idx != IW'(i));
        end
    end

    assign w_hide = LZ_EN & (r_idx != '0) & w_zero_hi;

    seg7_glyph u_glyph (
        .i_nibble   (w_nibble),
        .i_hex_mode (HEX_EN),
        .o_glyph    (w_glyph)
    );

    // Shadow copy of the display word and decimal points.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_dp     <= '0;
        end else if (load) begin
            r_shadow <= din;
            r_dp     <= dp_in;
        end else begin
            r_shadow <= r_shadow;
            r_dp     <= r_dp;
        end
    end

    // Prescaler and digit index; the index advances on the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
            r_idx   <= r_idx;
        end
    end

    // Output registers: blank for the cycle following a tick, else show the digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an    <= '1;
            r_frame <= 1'b0;
        end else if (w_tick) begin
            r_seg   <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an    <= AN_GAP;
            r_frame <= (r_idx == IDX_LAST);
        end else begin
            r_seg   <= w_hide ? SEG_BLANK : w_glyph;
            r_dp_n  <= ~w_dp_bit;
            r_an    <= w_an_sel;
            r_frame <= 1'b0;
        end
    end

    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign an         = r_an;
    assign frame_tick = r_frame;

endmodule
